// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed host byte stream,
// packs little-endian 32-bit words into imem and releases the CPU on a good checksum.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [7:0]  SYNC  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [7:0]            csum_q, csum_d;
  logic [23:0]           asm_q, asm_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;
  logic [15:0]           wl_d;
  logic [15:0]           len_full;
  logic                  accept;

  assign accept   = rx_valid & rx_ready;
  assign len_full = {rx_data, len_q[7:0]};

  // State and datapath registers; all outputs are registered copies of next-state values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      asm_q        <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      rx_ready     <= 1'b1;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      csum_q       <= csum_d;
      asm_q        <= asm_d;
      imem_we      <= we_d;
      imem_addr    <= addr_d;
      imem_wdata   <= wdata_d;
      words_loaded <= wl_d;
      rx_ready     <= (state_d != S_DONE) && (state_d != S_ERROR);
      cpu_hold     <= (state_d != S_DONE);
      done         <= (state_d == S_DONE);
      error        <= (state_d == S_ERROR);
    end
  end

  // Frame parser: next state plus byte packing, checksum and write generation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    wl_d       = words_loaded;

    if (start) begin
      // Abort wins over any byte presented in the same cycle
      state_d    = S_IDLE;
      len_d      = '0;
      byte_idx_d = '0;
      word_idx_d = '0;
      csum_d     = '0;
      asm_d      = '0;
      wl_d       = '0;
    end else if (accept) begin
      unique case (state_q)
        S_IDLE: if (rx_data == SYNC) state_d = S_LEN0;
        S_LEN0: begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d      = len_full;
          byte_idx_d = '0;
          word_idx_d = '0;
          csum_d     = '0;
          wl_d       = '0;
          if (32'(len_full) > DEPTH)  state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
        S_DATA: begin
          csum_d     = csum_q ^ rx_data;
          asm_d      = {rx_data, asm_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            wdata_d    = {rx_data, asm_q};
            word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            wl_d       = words_loaded + 16'd1;
            if (words_loaded == len_q - 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM:  state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
        default: ;
      endcase
    end
  end

endmodule
